// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: 8N1 frames on o_tx, sticky overflow on push-when-full.
// Optional UART_TX_PARITY_EN adds one even-parity bit between data and stop (8E1).
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_data,
  input  logic                  i_data_v,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_busy,
  output logic                  o_overflow,
  output logic                  o_tx
);

  localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2;
  localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_tx, r_overflow, r_full, r_busy;

  state_t            w_state_nxt;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        w_bit_nxt;
  logic [7:0]        w_shift_nxt;
  logic              w_tx_nxt, w_pop, w_push, w_nonempty, w_baud_end;
  logic [CNT_W-1:0]  w_count_nxt;

  // Occupancy is judged at start of cycle: a same-cycle pop never makes room for a push.
  assign w_push     = i_data_v && (r_count != CNT_FULL);
  assign w_nonempty = (r_count != '0);
  assign w_baud_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next-state / line logic; o_tx is registered so the line value is set one state ahead.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BAUD_W'(1);
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_tx_nxt    = ^r_shift;
            w_state_nxt = S_PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
            w_tx_nxt  = r_shift[r_bit_idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (w_nonempty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_baud_nxt  = '0;
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_full     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CNT_FULL);
      r_busy     <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      r_overflow <= r_overflow | (i_data_v & ~w_push);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_tx       = r_tx;
  assign o_level    = r_count;
  assign o_full     = r_full;
  assign o_busy     = r_busy;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue/frame-timing reference model.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int DL2 = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   i_data = 8'h00;
  logic         i_data_v = 1'b0;
  logic         o_full, o_busy, o_overflow, o_tx;
  logic [DL2:0] o_level;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_data_v(i_data_v),
    .o_full(o_full), .o_level(o_level), .o_busy(o_busy),
    .o_overflow(o_overflow), .o_tx(o_tx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: queued bytes, the frame on the line and when it was popped.
  logic [7:0] q[$];
  bit         m_act = 1'b0;
  int         m_pop = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 1'b0;
  int         cyc = 0;

  task automatic model_edge(input bit r, input bit v, input logic [7:0] d);
    int  sz;
    bit  do_pop;
    cyc++;
    if (r) begin
      q.delete();
      m_act = 1'b0;
      m_ovf = 1'b0;
      return;
    end
    sz = q.size();
    if (m_act && (cyc == m_pop + FRAME_CYC)) m_act = 1'b0;
    do_pop = !m_act && (sz > 0);
    if (v) begin
      if (sz < DEPTH) q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (do_pop) begin
      m_byte = q.pop_front();
      m_act  = 1'b1;
      m_pop  = cyc;
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_act) return 1'b1;
    b = (cyc - m_pop) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[3'(b - 1)];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  function automatic logic [6:0] exp_vec();
    return {exp_tx(), (m_act || q.size() > 0), (q.size() == DEPTH), m_ovf, 3'(q.size())};
  endfunction

  task automatic tick(input bit r, input bit v, input logic [7:0] d);
    rst = r; i_data_v = v; i_data = d;
    @(posedge clk);
    model_edge(r, v, d);
    #1;
    rst = 1'b0; i_data_v = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00);
    n_chk++; if (o_tx !== 1'b1) $display("FAIL reset_tx got=%b exp=1", o_tx); else n_pass++;
    n_chk++; if (o_level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", o_level); else n_pass++;
    n_chk++; if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", o_busy); else n_pass++;
    n_chk++; if (o_overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", o_overflow); else n_pass++;
    n_chk++; if (o_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", o_full); else n_pass++;
  endtask

  task automatic test_single();
    logic [10:0] pat;
    logic [7:0]  b;
    logic        tx_log [0:FRAME_CYC+3];
    logic        busy_log [0:FRAME_CYC+3];
`ifdef UART_TX_PARITY_EN
    b = 8'h07; pat = 11'b11000001110;
`else
    b = 8'h41; pat = 11'b01010000010;
`endif
    for (int i = 0; i <= FRAME_CYC + 3; i++) begin
      tick(1'b0, (i == 0), b);
      tx_log[i] = o_tx; busy_log[i] = o_busy;
      n_chk++;
      if ({o_tx, o_busy, o_full, o_overflow, o_level} !== exp_vec())
        $display("FAIL single_cyc t=%0d got=%b exp=%b", cyc, {o_tx, o_busy, o_full, o_overflow, o_level}, exp_vec());
      else n_pass++;
    end
    n_chk++; if (tx_log[0] !== 1'b1) $display("FAIL single_latency got=%b exp=1", tx_log[0]); else n_pass++;
    for (int k = 0; k < FRAME_BITS; k++) begin
      n_chk++;
      if (tx_log[1 + CPB * k + 1] !== pat[k]) $display("FAIL single_bit%0d got=%b exp=%b", k, tx_log[1 + CPB * k + 1], pat[k]);
      else n_pass++;
    end
    n_chk++; if (busy_log[FRAME_CYC] !== 1'b1) $display("FAIL single_busy_stop got=%b exp=1", busy_log[FRAME_CYC]); else n_pass++;
    n_chk++; if (busy_log[FRAME_CYC+1] !== 1'b0) $display("FAIL single_busy_fall got=%b exp=0", busy_log[FRAME_CYC+1]); else n_pass++;
  endtask

  task automatic test_overflow();
    bit saw_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 8'($urandom));
      if (o_full === 1'b1) saw_full = 1'b1;
      n_chk++;
      if ({o_tx, o_busy, o_full, o_overflow, o_level} !== exp_vec())
        $display("FAIL ovf_push t=%0d got=%b exp=%b", cyc, {o_tx, o_busy, o_full, o_overflow, o_level}, exp_vec());
      else n_pass++;
    end
    n_chk++; if (o_overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", o_overflow); else n_pass++;
    n_chk++; if (saw_full !== 1'b1) $display("FAIL ovf_full_seen got=%b exp=1", saw_full); else n_pass++;
    for (int i = 0; i < 5 * FRAME_CYC + 4; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      n_chk++;
      if ({o_tx, o_busy, o_full, o_overflow, o_level} !== exp_vec())
        $display("FAIL ovf_drain t=%0d got=%b exp=%b", cyc, {o_tx, o_busy, o_full, o_overflow, o_level}, exp_vec());
      else n_pass++;
    end
    n_chk++; if (o_busy !== 1'b0) $display("FAIL ovf_done_busy got=%b exp=0", o_busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic        tx_log [0:2*FRAME_CYC+3];
    logic [19:0] pat = 20'b11010101001010101010;
    for (int i = 0; i <= 2 * FRAME_CYC + 3; i++) begin
      tick(1'b0, (i < 2), (i == 0) ? 8'h55 : 8'hAA);
      tx_log[i] = o_tx;
      n_chk++;
      if ({o_tx, o_busy, o_full, o_overflow, o_level} !== exp_vec())
        $display("FAIL b2b_cyc t=%0d got=%b exp=%b", cyc, {o_tx, o_busy, o_full, o_overflow, o_level}, exp_vec());
      else n_pass++;
    end
`ifndef UART_TX_PARITY_EN
    for (int k = 0; k < 20; k++) begin
      n_chk++;
      if (tx_log[1 + CPB * k + 1] !== pat[k]) $display("FAIL b2b_bit%0d got=%b exp=%b", k, tx_log[1 + CPB * k + 1], pat[k]);
      else n_pass++;
    end
`endif
    n_chk++; if (tx_log[2 * FRAME_CYC + 1] !== 1'b1) $display("FAIL b2b_idle got=%b exp=1", tx_log[2 * FRAME_CYC + 1]); else n_pass++;
  endtask

  task automatic test_mid_reset();
    // Force overflow first so its clearing by reset is observable.
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 8'($urandom));
    for (int i = 0; i < 5 * FRAME_CYC + 4; i++) tick(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'($urandom));
    tick(1'b0, 1'b1, 8'($urandom));
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 8'h00);
    n_chk++; if (o_level !== 3'd3) $display("FAIL mrst_pre_level got=%0d exp=3", o_level); else n_pass++;
    tick(1'b1, 1'b0, 8'h00);
    n_chk++; if (o_tx !== 1'b1) $display("FAIL mrst_tx got=%b exp=1", o_tx); else n_pass++;
    n_chk++; if (o_level !== 3'd0) $display("FAIL mrst_level got=%0d exp=0", o_level); else n_pass++;
    n_chk++; if (o_overflow !== 1'b0) $display("FAIL mrst_ovf got=%b exp=0", o_overflow); else n_pass++;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      n_chk++;
      if ({o_tx, o_busy, o_full, o_overflow, o_level} !== {1'b1, 6'b000000})
        $display("FAIL mrst_quiet t=%0d got=%b exp=%b", cyc, {o_tx, o_busy, o_full, o_overflow, o_level}, 7'b1000000);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int pct;
    for (int i = 0; i < 1800; i++) begin
      pct = (i < 600) ? 5 : (i < 1200) ? 40 : 90;
      tick(($urandom_range(0, 599) == 0), ($urandom_range(0, 99) < pct), 8'($urandom));
      n_chk++;
      if ({o_tx, o_busy, o_full, o_overflow, o_level} !== exp_vec())
        $display("FAIL rand_cyc t=%0d got=%b exp=%b", cyc, {o_tx, o_busy, o_full, o_overflow, o_level}, exp_vec());
      else n_pass++;
    end
    for (int i = 0; i < (DEPTH + 2) * FRAME_CYC; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      n_chk++;
      if ({o_tx, o_busy, o_full, o_overflow, o_level} !== exp_vec())
        $display("FAIL rand_drain t=%0d got=%b exp=%b", cyc, {o_tx, o_busy, o_full, o_overflow, o_level}, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
